// File: rtl/stream_packer_if.sv
// Narrow element stream in (queue dequeue side), packed wide word stream out.
interface stream_packer_if #(
  parameter int DATA_WIDTH = 4,
  parameter int RATIO      = 4
);
  localparam int LW = $clog2(RATIO + 1);

  logic                        in_valid;
  logic [DATA_WIDTH-1:0]       in_data;
  logic                        in_ready;
  logic                        flush;
  logic                        out_valid;
  logic [DATA_WIDTH*RATIO-1:0] out_data;
  logic [LW-1:0]               out_lanes;
  logic                        out_ready;

  modport master (
    output in_valid,
    output in_data,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_lanes
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_lanes
  );
endinterface

// File: rtl/stream_packer.sv
// Packs RATIO queue elements into one wide word; flush emits a partial word.
module stream_packer #(
  parameter int DATA_WIDTH = 4,
  parameter int RATIO      = 4
) (
  input  logic            clk,
  input  logic            rst,
  stream_packer_if.slave  bus
);
  localparam int LW = $clog2(RATIO + 1);

  typedef enum logic {
    FILL,
    EMIT
  } state_e;

  typedef logic [RATIO-1:0][DATA_WIDTH-1:0] lanes_t;

  state_e        state_q, state_d;
  lanes_t        lane_q, lane_d;
  logic [LW-1:0] count_q, count_d;
  logic [LW-1:0] nlan_q, nlan_d;

  logic in_ready;
  logic accept;
  logic handoff;

  // In EMIT the slot frees only on handoff, so pop in lockstep with it.
  assign in_ready = ~rst & ((state_q == FILL) | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;
  assign handoff  = (state_q == EMIT) & bus.out_ready;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    count_d = count_q;
    nlan_d  = nlan_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          for (int i = 0; i < RATIO; i++) begin
            if (count_q == LW'(i)) begin
              lane_d[i] = bus.in_data;
            end
          end
          count_d = count_q + 1'b1;
          if ((count_q == LW'(RATIO - 1)) || bus.flush) begin
            state_d = EMIT;
            nlan_d  = count_q + 1'b1;
            count_d = '0;
          end
        end else if (bus.flush && (count_q != '0)) begin
          state_d = EMIT;
          nlan_d  = count_q;
          count_d = '0;
        end
      end
      EMIT: begin
        if (handoff) begin
          state_d = FILL;
          lane_d  = '0;
          nlan_d  = '0;
          count_d = '0;
          if (accept) begin
            lane_d[0] = bus.in_data;
            count_d   = LW'(1);
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      lane_q  <= '0;
      count_q <= '0;
      nlan_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      count_q <= count_d;
      nlan_q  <= nlan_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_data  = lane_q;
  assign bus.out_lanes = nlan_q;
endmodule

// File: tb/tb_stream_packer.sv
// Scoreboard bench for stream_packer (DATA_WIDTH=4, RATIO=4).
module tb_stream_packer;
  localparam int DW = 4;
  localparam int R  = 4;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_packer_if #(.DATA_WIDTH(DW), .RATIO(R)) bus ();

  stream_packer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  logic [DW-1:0]   src[$];
  logic [R*DW-1:0] sb_data[$];
  logic [LW-1:0]   sb_lanes[$];
  int              hand_cyc[$];
  logic [R*DW-1:0] hand_data[$];

  logic ordy;
  logic flush_now;

  logic            m_out;
  int              m_cnt;
  logic [R*DW-1:0] m_word;

  logic [R*DW-1:0] last_data;
  logic [LW-1:0]   last_lanes;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_out  = 1'b0;
    m_cnt  = 0;
    m_word = '0;
    sb_data.delete();
    sb_lanes.delete();
  endtask

  // Drive at negedge, sample just before the next posedge, update model.
  task automatic cycle();
    logic          acc;
    logic          hnd;
    logic          exp_rdy;
    logic [DW-1:0] el;
    el            = '0;
    bus.in_valid  = (src.size() > 0);
    bus.in_data   = (src.size() > 0) ? src[0] : DW'($urandom);
    bus.flush     = flush_now;
    bus.out_ready = ordy;
    #4;
    exp_rdy = !rst && (!m_out || ordy);
    chk("in_ready", bus.in_ready, exp_rdy);
    chk("out_valid", bus.out_valid, m_out);
    acc = bus.in_valid && bus.in_ready;
    hnd = bus.out_valid && bus.out_ready;
    if (hnd) begin
      if (sb_data.size() == 0) begin
        chk("sb_underflow", sb_data.size(), 1);
      end else begin
        chk("out_data", bus.out_data, sb_data.pop_front());
        chk("out_lanes", bus.out_lanes, sb_lanes.pop_front());
      end
      last_data  = bus.out_data;
      last_lanes = bus.out_lanes;
      hand_cyc.push_back(cyc);
      hand_data.push_back(bus.out_data);
    end
    if (acc && src.size() > 0) el = src.pop_front();
    if (rst) begin
      m_reset();
    end else if (m_out) begin
      if (ordy) begin
        m_out = 1'b0;
        if (acc) begin
          m_word = {{(R*DW-DW){1'b0}}, el};
          m_cnt  = 1;
        end
      end
    end else begin
      if (acc) begin
        m_word[m_cnt*DW +: DW] = el;
        m_cnt++;
      end
      if (m_cnt == R || (flush_now && m_cnt > 0)) begin
        sb_data.push_back(m_word);
        sb_lanes.push_back(LW'(m_cnt));
        m_out  = 1'b1;
        m_word = '0;
        m_cnt  = 0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic push(int first, int last);
    for (int v = first; v <= last; v++) src.push_back(DW'(v));
  endtask

  int n;

  initial begin
    ordy          = 1'b1;
    flush_now     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    last_data     = '0;
    last_lanes    = '0;
    m_reset();

    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_lanes", bus.out_lanes, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // full word, immediate handoff
    push(1, 4);
    repeat (5) cycle();
    chk("t1_data", last_data, 16'h4321);
    chk("t1_lanes", last_lanes, 4);

    // backpressure holds word and stalls the queue
    ordy = 1'b0;
    push(1, 5);
    repeat (5) cycle();
    chk("t2_hold", bus.out_data, 16'h4321);
    chk("t2_left", src.size(), 1);
    ordy = 1'b1;
    cycle();
    chk("t2_data", last_data, 16'h4321);
    chk("t2_popped", src.size(), 0);
    flush_now = 1'b1;
    cycle();
    flush_now = 1'b0;
    cycle();
    chk("t2_lane0", last_data, 16'h0005);
    chk("t2_lanes", last_lanes, 1);

    // flush after partial fill, then flush with nothing held
    push(5, 6);
    repeat (2) cycle();
    flush_now = 1'b1;
    cycle();
    flush_now = 1'b0;
    cycle();
    chk("t3_data", last_data, 16'h0065);
    chk("t3_lanes", last_lanes, 2);
    n = hand_cyc.size();
    flush_now = 1'b1;
    cycle();
    flush_now = 1'b0;
    cycle();
    chk("t3_empty_flush", bus.out_valid, 0);
    chk("t3_no_word", hand_cyc.size(), n);

    // flush in the same cycle as the last pop
    push(7, 8);
    cycle();
    flush_now = 1'b1;
    cycle();
    flush_now = 1'b0;
    cycle();
    chk("t4_data", last_data, 16'h0087);
    chk("t4_lanes", last_lanes, 2);

    // continuous stream, full throughput
    n = hand_cyc.size();
    push(1, 12);
    repeat (13) cycle();
    chk("t5_words", hand_cyc.size() - n, 3);
    if (hand_cyc.size() >= n + 3) begin
      chk("t5_w0", hand_data[n], 16'h4321);
      chk("t5_w1", hand_data[n+1], 16'h8765);
      chk("t5_w2", hand_data[n+2], 16'hCBA9);
      chk("t5_gap0", hand_cyc[n+1] - hand_cyc[n], 4);
      chk("t5_gap1", hand_cyc[n+2] - hand_cyc[n+1], 4);
    end

    // reset mid-word discards held lanes
    push(1, 2);
    repeat (2) cycle();
    rst = 1'b1;
    #1;
    m_reset();
    chk("t6_rst_data", bus.out_data, 0);
    chk("t6_rst_valid", bus.out_valid, 0);
    chk("t6_rst_lanes", bus.out_lanes, 0);
    chk("t6_rst_ready", bus.in_ready, 0);
    @(negedge clk);
    repeat (2) cycle();
    rst = 1'b0;
    push(3, 6);
    repeat (5) cycle();
    chk("t6_data", last_data, 16'h6543);
    chk("t6_lanes", last_lanes, 4);

    repeat (2) cycle();
    chk("sb_empty", sb_data.size(), 0);
    chk("src_empty", src.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
